// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional alignment trap is enabled with the PC_ALIGN_CHECK_EN macro.
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted,
    StTrap
  } pc_state_e;

  typedef enum logic [1:0] {
    RedirNone,
    RedirBr,
    RedirJ,
    RedirJr
  } redir_src_e;

  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned JSEG_MSB = 28;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-address logic: pc+4, branch/jump/jr targets and fixed-priority select.
// Shared by all builds, including PC_ALIGN_CHECK_EN.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 16,
  parameter int unsigned JIDX_W = 26
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              jump_en,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic              jr_en,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_plus4,
  output redir_src_e        sel,
  output logic [ADDR_W-1:0] target
);

  logic signed [OFF_W-1:0]  off_s;
  logic        [ADDR_W-1:0] off_ext;
  logic        [ADDR_W-1:0] j_low;
  logic        [ADDR_W-1:0] br_target;
  logic        [ADDR_W-1:0] j_target;

  assign pc_plus4 = pc + ADDR_W'(PC_STEP);

  // Signed size cast sign-extends the word offset before scaling to bytes.
  assign off_s     = branch_off;
  assign off_ext   = ADDR_W'(off_s);
  assign br_target = pc_plus4 + {off_ext[ADDR_W-3:0], 2'b00};

  assign j_low    = ADDR_W'({jump_idx, 2'b00});
  assign j_target = {pc_plus4[ADDR_W-1:JSEG_MSB], j_low[JSEG_MSB-1:0]};

  always_comb begin
    sel    = RedirNone;
    target = pc_plus4;
    if (jr_en) begin
      sel    = RedirJr;
      target = jr_target;
    end else if (jump_en) begin
      sel    = RedirJ;
      target = j_target;
    end else if (branch_taken) begin
      sel    = RedirBr;
      target = br_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with fetch handshake, stall-captured redirects and halt/resume.
// Define PC_ALIGN_CHECK_EN to add misalign_err and the TRAP state.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       OFF_W     = 16,
  parameter int unsigned       JIDX_W    = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ready,
  input  logic              branch_taken,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              jump_en,
  input  logic [JIDX_W-1:0] jump_idx,
  input  logic              jr_en,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              halted,
  output logic              redirect_pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  redir_src_e        sel;
  logic [ADDR_W-1:0] target;
  logic              redir;
  logic              bad_tgt;

  pc_target_calc #(
    .ADDR_W(ADDR_W),
    .OFF_W (OFF_W),
    .JIDX_W(JIDX_W)
  ) u_target_calc (
    .pc          (pc_q),
    .branch_taken(branch_taken),
    .branch_off  (branch_off),
    .jump_en     (jump_en),
    .jump_idx    (jump_idx),
    .jr_en       (jr_en),
    .jr_target   (jr_target),
    .pc_plus4    (pc_plus4),
    .sel         (sel),
    .target      (target)
  );

  assign redir = (sel != RedirNone);

`ifdef PC_ALIGN_CHECK_EN
  assign bad_tgt      = redir && (target[1:0] != 2'b00);
  assign misalign_err = (state_q == StTrap);
`else
  assign bad_tgt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        if (bad_tgt) begin
          state_d = StTrap;
        end else if (redir) begin
          pend_d     = 1'b1;
          pend_tgt_d = target;
        end
      end
      StRun: begin
        if (bad_tgt) begin
          state_d = StTrap;
        end else begin
          if (fetch_ready) begin
            // A live redirect supersedes anything captured earlier.
            if (redir) begin
              pc_d = target;
            end else if (pend_q) begin
              pc_d = pend_tgt_q;
            end else begin
              pc_d = pc_plus4;
            end
            pend_d = 1'b0;
          end else if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
          if (halt_req) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        if (bad_tgt) begin
          state_d = StTrap;
        end else begin
          if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
          end
          if (resume && !halt_req) begin
            state_d = StRun;
          end
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      StTrap: begin
        state_d = StTrap;
      end
`endif
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = (state_q == StRun);
  assign halted        = (state_q == StHalted);
  assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected post-edge state is queued per step and checked after
// the edge. The misalignment trap steps run only when PC_ALIGN_CHECK_EN is defined.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned JIDX_W = 26;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_ready;
  logic              branch_taken;
  logic [OFF_W-1:0]  branch_off;
  logic              jump_en;
  logic [JIDX_W-1:0] jump_idx;
  logic              jr_en;
  logic [ADDR_W-1:0] jr_target;
  logic              halt_req;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              pc_valid;
  logic              halted;
  logic              redirect_pend;
`ifdef PC_ALIGN_CHECK_EN
  logic              misalign_err;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(32'h0000_0000),
    .OFF_W    (OFF_W),
    .JIDX_W   (JIDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_ready  (fetch_ready),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump_en      (jump_en),
    .jump_idx     (jump_idx),
    .jr_en        (jr_en),
    .jr_target    (jr_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .redirect_pend(redirect_pend)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              valid;
    logic              halted;
    logic              pend;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic clr();
    branch_taken = 1'b0;
    branch_off   = '0;
    jump_en      = 1'b0;
    jump_idx     = '0;
    jr_en        = 1'b0;
    jr_target    = '0;
    halt_req     = 1'b0;
    resume       = 1'b0;
  endtask

  // Queue the expected post-edge state, clock once, then check the oldest entry.
  task automatic step(input string tag, input logic [ADDR_W-1:0] epc, input logic ev,
                      input logic eh, input logic ep);
    exp_t e;
    obs_t got;
    e.tag          = tag;
    e.exp.pc       = epc;
    e.exp.pc_plus4 = epc + 32'd4;
    e.exp.valid    = ev;
    e.exp.halted   = eh;
    e.exp.pend     = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e            = sb.pop_front();
    got.pc       = pc;
    got.pc_plus4 = pc_plus4;
    got.valid    = pc_valid;
    got.halted   = halted;
    got.pend     = redirect_pend;
    checks++;
    assert (got === e.exp)
    else begin
      failures++;
      $error("FAIL %s: got pc=%h pc4=%h v=%b h=%b p=%b, want pc=%h pc4=%h v=%b h=%b p=%b",
             e.tag, got.pc, got.pc_plus4, got.valid, got.halted, got.pend,
             e.exp.pc, e.exp.pc_plus4, e.exp.valid, e.exp.halted, e.exp.pend);
    end
  endtask

  initial begin
    clr();
    reset       = 1'b0;
    fetch_ready = 1'b1;

    // Reset, boot and free run
    step("rst0", 32'h0, 1'b0, 1'b0, 1'b0);
    step("rst1", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("boot", 32'h0, 1'b1, 1'b0, 1'b0);
    step("run4", 32'h4, 1'b1, 1'b0, 1'b0);
    step("run8", 32'h8, 1'b1, 1'b0, 1'b0);
    step("run12", 32'hC, 1'b1, 1'b0, 1'b0);

    // Branches: negative offset and modulo wrap
    jr_en = 1'b1; jr_target = 32'h40;
    step("jr40", 32'h40, 1'b1, 1'b0, 1'b0);
    clr(); branch_taken = 1'b1; branch_off = 16'hFFFC;
    step("br_neg", 32'h34, 1'b1, 1'b0, 1'b0);
    clr(); jr_en = 1'b1; jr_target = 32'hFFFF_FFF0;
    step("jr_hi", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    clr(); branch_taken = 1'b1; branch_off = 16'h7FFF;
    step("br_wrap", 32'h0001_FFF0, 1'b1, 1'b0, 1'b0);

    // Priority and jump target composition
    clr(); jr_en = 1'b1; jr_target = 32'h200; jump_en = 1'b1; jump_idx = 26'h3;
    branch_taken = 1'b1; branch_off = 16'h0010;
    step("prio", 32'h200, 1'b1, 1'b0, 1'b0);
    clr(); jump_en = 1'b1; jump_idx = 26'h5; branch_taken = 1'b1; branch_off = 16'h0010;
    step("j_over_br", 32'h14, 1'b1, 1'b0, 1'b0);
    clr(); jr_en = 1'b1; jr_target = 32'h1000_0000;
    step("jr_seg", 32'h1000_0000, 1'b1, 1'b0, 1'b0);
    clr(); jump_en = 1'b1; jump_idx = 26'h10;
    step("j_seg", 32'h1000_0040, 1'b1, 1'b0, 1'b0);

    // Stall capture, last redirect wins
    clr(); jr_en = 1'b1; jr_target = 32'h20;
    step("jr20", 32'h20, 1'b1, 1'b0, 1'b0);
    clr(); fetch_ready = 1'b0; jump_en = 1'b1; jump_idx = 26'h20;
    step("stall1", 32'h20, 1'b1, 1'b0, 1'b1);
    clr(); jr_en = 1'b1; jr_target = 32'h300;
    step("stall2", 32'h20, 1'b1, 1'b0, 1'b1);
    clr();
    step("stall3", 32'h20, 1'b1, 1'b0, 1'b1);
    fetch_ready = 1'b1;
    step("release", 32'h300, 1'b1, 1'b0, 1'b0);
    step("after_rel", 32'h304, 1'b1, 1'b0, 1'b0);

    // Halt with same-cycle branch, then resume
    branch_taken = 1'b1; branch_off = 16'hFF7E; halt_req = 1'b1;
    step("halt", 32'h100, 1'b0, 1'b1, 1'b0);
    clr();
    step("hold1", 32'h100, 1'b0, 1'b1, 1'b0);
    halt_req = 1'b1;
    step("hold_hreq", 32'h100, 1'b0, 1'b1, 1'b0);
    resume = 1'b1;
    step("hold_both", 32'h100, 1'b0, 1'b1, 1'b0);
    clr(); fetch_ready = 1'b0;
    step("hold_stall", 32'h100, 1'b0, 1'b1, 1'b0);
    fetch_ready = 1'b1; resume = 1'b1;
    step("resume", 32'h100, 1'b1, 1'b0, 1'b0);
    clr();
    step("post_res", 32'h104, 1'b1, 1'b0, 1'b0);

    // Reset during a stall discards the pending redirect
    fetch_ready = 1'b0; jr_en = 1'b1; jr_target = 32'h500;
    step("pend500", 32'h104, 1'b1, 1'b0, 1'b1);
    clr(); reset = 1'b0;
    step("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; fetch_ready = 1'b1;
    step("reboot", 32'h0, 1'b1, 1'b0, 1'b0);
    step("no_stale", 32'h4, 1'b1, 1'b0, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
    jr_en = 1'b1; jr_target = 32'h102;
    step("trap", 32'h4, 1'b0, 1'b0, 1'b0);
    clr();
    step("trap_hold", 32'h4, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (misalign_err === 1'b1)
    else begin
      failures++;
      $error("FAIL misalign_err: got %b want 1", misalign_err);
    end
    reset = 1'b0;
    step("trap_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (misalign_err === 1'b0)
    else begin
      failures++;
      $error("FAIL misalign_clr: got %b want 0", misalign_err);
    end
    reset = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
